// File: rtl/insight_tl_e_sink_tracker.sv
// TileLink E-channel (GrantAck) stage: DEPTH-entry beat FIFO plus an
// outstanding-grant scoreboard indexed by sink ID, with registered error pulses.
module insight_tl_e_sink_tracker #(
  parameter int SINK_W = 2,
  parameter int DEPTH  = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     grant_valid,
  input  logic [SINK_W-1:0]        grant_sink,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SINK_W-1:0]        in_sink,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SINK_W-1:0]        out_sink,
  output logic [(1<<SINK_W)-1:0]   pending,
  output logic [SINK_W:0]          pending_count,
  output logic                     err_valid,
  output logic [1:0]               err_code,
  output logic [SINK_W-1:0]        err_sink
);

  localparam int NSINK = 1 << SINK_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [SINK_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  occ;

  logic              full, in_fire, out_fire;
  logic              ack_ok, ack_bad, retire_same, dup_grant;
  logic [NSINK-1:0]  clr_mask, set_mask, pending_nxt;
  logic [SINK_W:0]   count_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) ptr_inc = '0;
    else                        ptr_inc = p + PTR_W'(1);
  endfunction

  assign full      = (occ == CNT_W'(DEPTH));
  assign in_ready  = !full && !reset;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (occ != '0);
  assign out_fire  = out_valid && out_ready;
  assign out_sink  = out_valid ? mem[rd_ptr] : '0;

  // Ack legality is judged against the scoreboard as it stood before this edge.
  assign ack_ok      = in_fire && pending[in_sink];
  assign ack_bad     = in_fire && !pending[in_sink];
  assign retire_same = ack_ok && (in_sink == grant_sink);
  assign dup_grant   = grant_valid && pending[grant_sink] && !retire_same;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (ack_ok)      clr_mask[in_sink]    = 1'b1;
    if (grant_valid) set_mask[grant_sink] = 1'b1;
    pending_nxt = (pending & ~clr_mask) | set_mask;
    count_nxt = '0;
    for (int i = 0; i < NSINK; i++) begin
      count_nxt = count_nxt + (SINK_W+1)'(pending_nxt[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (ack_ok) mem[wr_ptr] <= in_sink;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      pending       <= '0;
      pending_count <= '0;
      err_valid     <= 1'b0;
      err_code      <= 2'b00;
      err_sink      <= '0;
    end else begin
      if (ack_ok)   wr_ptr <= ptr_inc(wr_ptr);
      if (out_fire) rd_ptr <= ptr_inc(rd_ptr);
      case ({ack_ok, out_fire})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
      pending       <= pending_nxt;
      pending_count <= count_nxt;
      err_valid     <= ack_bad || dup_grant;
      err_code      <= {dup_grant, ack_bad};
      if (ack_bad)        err_sink <= in_sink;
      else if (dup_grant) err_sink <= grant_sink;
      else                err_sink <= '0;
    end
  end

endmodule

// File: tb/tb_insight_tl_e_sink_tracker.sv
// Bench for insight_tl_e_sink_tracker: directed scenarios plus a cycle-level
// reference model and an in-order scoreboard of expected out_sink beats.
module tb_insight_tl_e_sink_tracker;
  localparam int SINK_W = 2;
  localparam int DEPTH  = 2;
  localparam int NSINK  = 1 << SINK_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              grant_valid = 1'b0;
  logic [SINK_W-1:0] grant_sink = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SINK_W-1:0] in_sink = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [SINK_W-1:0] out_sink;
  logic [NSINK-1:0]  pending;
  logic [SINK_W:0]   pending_count;
  logic              err_valid;
  logic [1:0]        err_code;
  logic [SINK_W-1:0] err_sink;

  int vectors = 0;
  int miscompares = 0;

  insight_tl_e_sink_tracker #(.SINK_W(SINK_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .grant_valid(grant_valid), .grant_sink(grant_sink),
    .in_valid(in_valid), .in_ready(in_ready), .in_sink(in_sink),
    .out_valid(out_valid), .out_ready(out_ready), .out_sink(out_sink),
    .pending(pending), .pending_count(pending_count),
    .err_valid(err_valid), .err_code(err_code), .err_sink(err_sink)
  );

  always #5 clock = ~clock;

  // Reference model state (what the DUT should show after the latest edge).
  logic [NSINK-1:0]  m_pending = '0;
  logic              m_err_valid = 1'b0;
  logic [1:0]        m_err_code = 2'b00;
  logic [SINK_W-1:0] m_err_sink = '0;
  logic [NSINK-1:0]  n_pending;
  logic              n_err_valid;
  logic [1:0]        n_err_code;
  logic [SINK_W-1:0] n_err_sink;
  logic [SINK_W-1:0] sb_q[$];
  bit                seen_reset = 1'b0;

  always @(negedge clock) begin
    logic exp_rdy, fire, ok, bad, dup;
    exp_rdy = !reset && (sb_q.size() < DEPTH);
    if (seen_reset) begin
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL mon_in_ready t=%0t got %b want %b", $time, in_ready, exp_rdy);
      end
      vectors++;
      if (out_valid !== (sb_q.size() != 0)) begin
        miscompares++;
        $display("FAIL mon_out_valid t=%0t got %b want %b", $time, out_valid, sb_q.size() != 0);
      end
      if (sb_q.size() != 0) begin
        vectors++;
        if (out_sink !== sb_q[0]) begin
          miscompares++;
          $display("FAIL mon_out_sink t=%0t got %0d want %0d", $time, out_sink, sb_q[0]);
        end
      end
      vectors++;
      if (pending !== m_pending || pending_count !== ($countones(m_pending))) begin
        miscompares++;
        $display("FAIL mon_pending t=%0t got %b/%0d want %b/%0d", $time,
                 pending, pending_count, m_pending, $countones(m_pending));
      end
      vectors++;
      if ({err_valid, err_code, err_sink} !== {m_err_valid, m_err_code, m_err_sink}) begin
        miscompares++;
        $display("FAIL mon_err t=%0t got v%b c%b s%0d want v%b c%b s%0d", $time,
                 err_valid, err_code, err_sink, m_err_valid, m_err_code, m_err_sink);
      end
    end
    if (reset) begin
      sb_q.delete();
      n_pending = '0;
      n_err_valid = 1'b0;
      n_err_code = 2'b00;
      n_err_sink = '0;
    end else begin
      fire = in_valid && exp_rdy;
      ok  = fire && m_pending[in_sink];
      bad = fire && !m_pending[in_sink];
      n_pending = m_pending;
      if (ok) n_pending[in_sink] = 1'b0;
      dup = grant_valid && n_pending[grant_sink];
      if (grant_valid) n_pending[grant_sink] = 1'b1;
      n_err_valid = ok ? dup : (bad || dup);
      n_err_code  = {dup, bad};
      n_err_sink  = bad ? in_sink : (dup ? grant_sink : '0);
      if (sb_q.size() != 0 && out_ready) void'(sb_q.pop_front());
      if (ok) sb_q.push_back(in_sink);
    end
  end

  always @(posedge clock) begin
    if (reset) seen_reset = 1'b1;
    m_pending   = n_pending;
    m_err_valid = n_err_valid;
    m_err_code  = n_err_code;
    m_err_sink  = n_err_sink;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready_high got %b want 0", in_ready);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready_low got %b want 1", in_ready);
    end
    cyc();
    vectors++;
    if ({out_valid, pending, pending_count, err_valid} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_idle got ov%b p%b pc%0d ev%b want all 0",
               out_valid, pending, pending_count, err_valid);
    end
  endtask

  task automatic test_grant_ack();
    out_ready = 1'b1;
    grant_valid = 1'b1; grant_sink = 2;
    cyc();
    grant_valid = 1'b0;
    vectors++;
    if (pending !== 4'b0100 || pending_count !== 3'd1) begin
      miscompares++;
      $display("FAIL grant_pending got %b/%0d want 0100/1", pending, pending_count);
    end
    in_valid = 1'b1; in_sink = 2;
    cyc();
    in_valid = 1'b0;
    vectors++;
    if (pending !== 4'b0000 || out_valid !== 1'b1 || out_sink !== 2'd2 || err_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_out got p%b ov%b os%0d ev%b want 0000 1 2 0",
               pending, out_valid, out_sink, err_valid);
    end
    cyc();
  endtask

  task automatic test_unexpected_ack();
    in_valid = 1'b1; in_sink = 1;
    cyc();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || err_valid !== 1'b1 || err_code !== 2'b01 || err_sink !== 2'd1) begin
      miscompares++;
      $display("FAIL unexpected_ack got ov%b ev%b ec%b es%0d want 0 1 01 1",
               out_valid, err_valid, err_code, err_sink);
    end
    cyc();
    vectors++;
    if (err_valid !== 1'b0 || err_code !== 2'b00) begin
      miscompares++;
      $display("FAIL unexpected_pulse_width got ev%b ec%b want 0 00", err_valid, err_code);
    end
  endtask

  task automatic test_dup_grant();
    grant_valid = 1'b1; grant_sink = 3;
    cyc();
    cyc();
    grant_valid = 1'b0;
    vectors++;
    if (err_valid !== 1'b1 || err_code !== 2'b10 || err_sink !== 2'd3 ||
        pending !== 4'b1000 || pending_count !== 3'd1) begin
      miscompares++;
      $display("FAIL dup_grant got ev%b ec%b es%0d p%b pc%0d want 1 10 3 1000 1",
               err_valid, err_code, err_sink, pending, pending_count);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_sink = 3;
    cyc();
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      grant_valid = 1'b1; grant_sink = SINK_W'(s);
      cyc();
    end
    grant_valid = 1'b0;
    in_valid = 1'b1; in_sink = 0;
    cyc();
    in_sink = 1;
    cyc();
    vectors++;
    if (in_ready !== 1'b0 || out_sink !== 2'd0) begin
      miscompares++;
      $display("FAIL bp_full got rdy%b os%0d want 0 0", in_ready, out_sink);
    end
    in_sink = 2;
    cyc();
    vectors++;
    if (in_ready !== 1'b0 || pending !== 4'b0100 || out_valid !== 1'b1 || out_sink !== 2'd0) begin
      miscompares++;
      $display("FAIL bp_hold got rdy%b p%b ov%b os%0d want 0 0100 1 0",
               in_ready, pending, out_valid, out_sink);
    end
    out_ready = 1'b1;
    cyc();
    vectors++;
    if (out_sink !== 2'd1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release got os%0d rdy%b want 1 1", out_sink, in_ready);
    end
    cyc();
    vectors++;
    if (out_valid !== 1'b1 || out_sink !== 2'd2 || in_ready !== 1'b1 || pending !== 4'b0000) begin
      miscompares++;
      $display("FAIL bp_enq_deq got ov%b os%0d rdy%b p%b want 1 2 1 0000",
               out_valid, out_sink, in_ready, pending);
    end
    in_valid = 1'b0;
    cyc();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain got ov%b want 0", out_valid);
    end
  endtask

  task automatic test_same_cycle_and_reset();
    out_ready = 1'b0;
    grant_valid = 1'b1; grant_sink = 0;
    cyc();
    in_valid = 1'b1; in_sink = 0;
    cyc();
    grant_valid = 1'b0; in_valid = 1'b0;
    vectors++;
    if (pending !== 4'b0001 || pending_count !== 3'd1 || err_valid !== 1'b0 ||
        out_valid !== 1'b1 || out_sink !== 2'd0) begin
      miscompares++;
      $display("FAIL same_cycle got p%b pc%0d ev%b ov%b os%0d want 0001 1 0 1 0",
               pending, pending_count, err_valid, out_valid, out_sink);
    end
    grant_valid = 1'b1; grant_sink = 1;
    cyc();
    reset = 1'b1;
    grant_sink = 2; in_valid = 1'b1; in_sink = 0; out_ready = 1'b1;
    cyc();
    vectors++;
    if ({in_ready, out_valid, out_sink, pending, pending_count, err_valid, err_code, err_sink} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset got rdy%b ov%b os%0d p%b pc%0d ev%b ec%b es%0d want all 0",
               in_ready, out_valid, out_sink, pending, pending_count, err_valid, err_code, err_sink);
    end
    reset = 1'b0;
    grant_valid = 1'b0; in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int s = 0; s < NSINK; s++) begin
      grant_valid = 1'b1; grant_sink = SINK_W'(s);
      cyc();
    end
    grant_valid = 1'b0;
    for (int s = 0; s < NSINK; s++) begin
      in_valid = 1'b1; in_sink = SINK_W'(NSINK - 1 - s);
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready beat %0d got %b want 1", s, in_ready);
      end
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      grant_valid = ($urandom_range(0, 2) == 0);
      grant_sink  = SINK_W'($urandom_range(0, NSINK - 1));
      in_valid    = ($urandom_range(0, 1) == 1);
      in_sink     = SINK_W'($urandom_range(0, NSINK - 1));
      out_ready   = ($urandom_range(0, 3) != 0);
      reset       = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 1'b0; grant_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    cyc();
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_grant_ack();
    test_unexpected_ack();
    test_dup_grant();
    test_backpressure();
    test_same_cycle_and_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/insight_tl_e_sink_tracker.md
# insight_tl_e_sink_tracker

Parametrised TileLink E-channel (GrantAck) stage for the hart data port. It buffers E-channel beats in a DEPTH-entry FIFO and keeps an outstanding-grant scoreboard indexed by sink ID. It reports protocol violations as single-cycle error pulses. It sits between the core's E-channel source and the fabric, and observes first beats of D-channel Grant/GrantData to the same hart.

## Interface
Parameters:
- SINK_W, 2 — width of the sink ID; scoreboard holds NSINK = 2^SINK_W entries.
- DEPTH, 2 — FIFO entries, ≥1, not required to be a power of two.

Ports:
- clock  in  1  — single clock; all state updates on its rising edge.
- reset  in  1  — synchronous, active-high.
- grant_valid  in  1  — a Grant/GrantData first beat needing an ack fires this cycle.
- grant_sink  in  SINK_W  — sink ID of that grant.
- in_valid  in  1  — E beat offered by the core.
- in_ready  out  1  — stage accepts the E beat.
- in_sink  in  SINK_W  — sink ID of the offered ack.
- out_valid  out  1  — E beat presented to the fabric.
- out_ready  in  1  — fabric accepts the beat.
- out_sink  out  SINK_W  — sink ID of the presented beat.
- pending  out  NSINK  — bit i set means a grant to sink i is awaiting its ack.
- pending_count  out  SINK_W+1  — population count of `pending`, registered.
- err_valid  out  1  — one-cycle error pulse.
- err_code  out  2  — bit0: unexpected ack; bit1: duplicate grant.
- err_sink  out  SINK_W  — sink ID associated with the error.

## Operation
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- in_ready = !full & !reset. There is no pass-through when full: a simultaneous out_fire does not free a slot in the same cycle.
- On in_fire, the ack is checked against `pending` as registered before this cycle.
  - If pending[in_sink] = 1: the bit is cleared and in_sink is enqueued.
  - If pending[in_sink] = 0: this is an unexpected ack. The beat is consumed and dropped (not enqueued), and err_code bit0 is set.
- On grant_valid:
  - If pending[grant_sink] = 0 (pre-cycle value), or the same cycle retires that sink via a valid ack, the bit is set.
  - Otherwise this is a duplicate grant: err_code bit1 is set and the bit stays 1.
- Same-sink grant and valid ack in one cycle: the ack clears, the grant sets, and the net result is pending = 1 with no error.
- Both errors in one cycle: err_code = 2'b11 and err_sink = in_sink.
  - Single error: err_sink is the sink of the offending event.
- err_valid, err_code and err_sink are registered. They are asserted the cycle after the event for exactly one cycle, and are 0 otherwise.
- The FIFO uses circular read/write pointers that wrap at DEPTH-1 → 0, plus an occupancy counter of width clog2(DEPTH+1).
  - Simultaneous enqueue and dequeue leaves occupancy unchanged.
- out_valid = occupancy ≠ 0. out_sink = head entry, stable while out_valid & !out_ready.
- pending_count is updated in the same cycle as `pending`, so both reflect the same edge.

## Timing
- Reset values: occupancy 0, pointers 0, pending all 0, pending_count 0, out_valid 0, out_sink 0, err_valid 0, err_code 0, err_sink 0.
  - in_ready is 0 while reset is high and 1 in the first cycle after reset deasserts.
- Inputs are ignored while reset is high. A reset asserted mid-operation discards all buffered beats and scoreboard state at that edge.
- Latency is 1 cycle: a beat enqueued at edge N is visible on out_valid/out_sink after edge N; there is no combinational in→out path.
- Throughput: one beat per cycle while out_ready = 1. With DEPTH = 1, a new beat cannot be accepted in the same cycle the held beat is dequeued, so throughput is one beat every two cycles.
- The error pulse appears on the cycle after the offending fire/grant. `pending` reflects the event after the same edge.

## Test plan
- Reset then idle: after reset deasserts, in_ready = 1, out_valid = 0, pending = 0, err_valid = 0.
- Grant sink 2, then ack sink 2 one cycle later with out_ready = 1:
  - pending = 4'b0100 after the grant edge; pending returns to 0 after the ack edge.
  - out_valid = 1 with out_sink = 2 one cycle after the ack; no error.
- Ack sink 1 with nothing pending: the beat is dropped and out_valid stays 0. Next cycle err_valid = 1, err_code = 01, err_sink = 1.
- Grant sink 3 twice on consecutive cycles: the second cycle raises err_code = 10 with err_sink = 3. pending[3] = 1 and pending_count = 1.
- Backpressure, DEPTH = 2: grant sinks 0–2, hold out_ready = 0, offer acks 0, 1, 2.
  - in_ready drops after two accepts, and ack 2 is held by the source.
  - Release out_ready: beats appear in order 0, 1, then 2 after it is accepted. Occupancy holds steady in simultaneous enqueue/dequeue cycles.
- Same-cycle grant and ack of pending sink 0: pending[0] stays 1, pending_count unchanged, no error, and sink 0 is enqueued. Assert reset mid-stream and check all outputs return to their reset values the next cycle.
